// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the 5-stage MIPS32 subset pipeline: opcodes,
// instruction classes and the contents of each pipeline register.
package pipe_mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } instr_class_e;

  // IF/ID: raw instruction word and the address it was fetched from
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } if_id_t;

  // ID/EX: decoded fields plus register-file operands read in ID
  typedef struct packed {
    instr_class_e cls;
    logic [5:0]   op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   dst;
    logic         wr;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  imm;
    logic [31:0]  pc;
  } id_ex_t;

  // EX/MEM: ALU result (or memory address) and store data
  typedef struct packed {
    instr_class_e cls;
    logic         wr;
    logic [4:0]   dst;
    logic [31:0]  alu;
    logic [31:0]  sdata;
  } ex_mem_t;

  // MEM/WB: ALU result and loaded memory data
  typedef struct packed {
    instr_class_e cls;
    logic         wr;
    logic [4:0]   dst;
    logic [31:0]  alu;
    logic [31:0]  lmd;
  } mem_wb_t;

  function automatic instr_class_e decode_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

endpackage

// File: rtl/mips32_regfile.sv
// 32 x 32-bit register file, two read ports and one write port.
// R0 reads as zero; a read of the register being written this cycle
// returns the incoming value so ID sees WB results without a stall.
module mips32_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);

  // Contents are deliberately not reset so preloaded values survive rst_n.
  logic [31:0] Reg [0:31];

  // Write port; R0 is never written
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      Reg[waddr] <= wdata;
    end
  end

  // Read port A with write-through bypass
  always_comb begin
    rdata_a = Reg[raddr_a];
    if (raddr_a == 5'd0) begin
      rdata_a = 32'd0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  // Read port B with write-through bypass
  always_comb begin
    rdata_b = Reg[raddr_b];
    if (raddr_b == 5'd0) begin
      rdata_b = 32'd0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32 subset pipeline (IF, ID, EX, MEM, WB) with
// a unified word-addressed memory, EX-stage forwarding, branches resolved
// in EX with a two-slot squash, and HLT that freezes the machine on retire.
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic clk1,
  input logic rst_n
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Architectural state (names kept visible for preload and inspection)
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic [31:0] pc_d;
  logic        halted_d;
  logic        taken_branch_d;
  logic        halt_fetch_q, halt_fetch_d;

  // Pipeline registers: data and separately-reset valid bits
  if_id_t  ifid_q,  ifid_d;
  id_ex_t  idex_q,  idex_d;
  ex_mem_t exmem_q, exmem_d;
  mem_wb_t memwb_q, memwb_d;
  logic    ifid_vld_q,  ifid_vld_d;
  logic    idex_vld_q,  idex_vld_d;
  logic    exmem_vld_q, exmem_vld_d;
  logic    memwb_vld_q, memwb_vld_d;

  // ID decode
  logic [5:0]   id_op;
  instr_class_e id_cls;
  logic [4:0]   id_rs, id_rt, id_rd;
  logic [31:0]  id_imm;
  logic         hlt_in_id;

  // Register file hookup
  logic [31:0] rf_a, rf_b;
  logic        rf_we;
  logic [31:0] wb_value;

  // EX
  logic [31:0] ex_a, ex_b, ex_alu, ex_target;
  logic        ex_taken;

  // MEM
  logic        mem_we;

  function automatic logic [AW-1:0] mem_idx(input logic [31:0] addr);
    return AW'(addr % MEM_WORDS);
  endfunction

  assign id_op     = ifid_q.ir[31:26];
  assign id_rs     = ifid_q.ir[25:21];
  assign id_rt     = ifid_q.ir[20:16];
  assign id_rd     = ifid_q.ir[15:11];
  assign id_imm    = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
  assign id_cls    = decode_class(id_op);
  assign hlt_in_id = ifid_vld_q && (id_cls == HALT);

  assign wb_value  = (memwb_q.cls == LOAD) ? memwb_q.lmd : memwb_q.alu;
  assign rf_we     = memwb_vld_q && memwb_q.wr && !HALTED;

  mips32_regfile u_rf (
    .clk     (clk1),
    .we      (rf_we),
    .waddr   (memwb_q.dst),
    .wdata   (wb_value),
    .raddr_a (id_rs),
    .rdata_a (rf_a),
    .raddr_b (id_rt),
    .rdata_b (rf_b)
  );

  // ---------------- IF ----------------
  // Next PC and IF/ID: a taken branch redirects and bubbles, a seen HLT freezes fetch
  always_comb begin
    pc_d         = PC;
    ifid_d       = ifid_q;
    ifid_vld_d   = 1'b0;
    halt_fetch_d = halt_fetch_q;
    if (ex_taken) begin
      pc_d = ex_target;
    end else if (halt_fetch_q || hlt_in_id || HALTED) begin
      halt_fetch_d = 1'b1;
    end else begin
      pc_d       = PC + 32'd1;
      ifid_d.ir  = Mem[mem_idx(PC)];
      ifid_d.pc  = PC;
      ifid_vld_d = 1'b1;
    end
  end

  // ---------------- ID ----------------
  // Decode into ID/EX; a taken branch in EX turns this slot into a bubble
  always_comb begin
    idex_d     = idex_q;
    idex_d.cls = id_cls;
    idex_d.op  = id_op;
    idex_d.rs  = id_rs;
    idex_d.rt  = id_rt;
    idex_d.dst = (id_cls == RR_ALU) ? id_rd : id_rt;
    idex_d.wr  = (id_cls == RR_ALU) || (id_cls == RM_ALU) || (id_cls == LOAD);
    idex_d.a   = rf_a;
    idex_d.b   = rf_b;
    idex_d.imm = id_imm;
    idex_d.pc  = ifid_q.pc;
    idex_vld_d = ifid_vld_q && !ex_taken;
  end

  // ---------------- EX ----------------
  // Operand forwarding: EX/MEM ALU results first, then MEM/WB (ALU or load)
  always_comb begin
    ex_a = idex_q.a;
    if (exmem_vld_q && exmem_q.wr && (exmem_q.cls != LOAD) &&
        (exmem_q.dst == idex_q.rs) && (idex_q.rs != 5'd0)) begin
      ex_a = exmem_q.alu;
    end else if (memwb_vld_q && memwb_q.wr &&
                 (memwb_q.dst == idex_q.rs) && (idex_q.rs != 5'd0)) begin
      ex_a = wb_value;
    end
    ex_b = idex_q.b;
    if (exmem_vld_q && exmem_q.wr && (exmem_q.cls != LOAD) &&
        (exmem_q.dst == idex_q.rt) && (idex_q.rt != 5'd0)) begin
      ex_b = exmem_q.alu;
    end else if (memwb_vld_q && memwb_q.wr &&
                 (memwb_q.dst == idex_q.rt) && (idex_q.rt != 5'd0)) begin
      ex_b = wb_value;
    end
  end

  // ALU, address generation and branch resolution
  always_comb begin
    case (idex_q.op)
      OP_ADD:                 ex_alu = ex_a + ex_b;
      OP_SUB:                 ex_alu = ex_a - ex_b;
      OP_AND:                 ex_alu = ex_a & ex_b;
      OP_OR:                  ex_alu = ex_a | ex_b;
      OP_SLT:                 ex_alu = {31'd0, ($signed(ex_a) < $signed(ex_b))};
      OP_MUL:                 ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW:  ex_alu = ex_a + idex_q.imm;
      OP_SUBI:                ex_alu = ex_a - idex_q.imm;
      OP_SLTI:                ex_alu = {31'd0, ($signed(ex_a) < $signed(idex_q.imm))};
      default:                ex_alu = 32'd0;
    endcase
    ex_target = idex_q.pc + 32'd1 + idex_q.imm;
    ex_taken  = idex_vld_q && (idex_q.cls == BRANCH) && !HALTED &&
                ((idex_q.op == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));
    exmem_d       = exmem_q;
    exmem_d.cls   = idex_q.cls;
    exmem_d.wr    = idex_q.wr;
    exmem_d.dst   = idex_q.dst;
    exmem_d.alu   = ex_alu;
    exmem_d.sdata = ex_b;
    exmem_vld_d   = idex_vld_q;
  end

  // ---------------- MEM ----------------
  // Load data read and store enable; nothing is written once halted
  always_comb begin
    memwb_d     = memwb_q;
    memwb_d.cls = exmem_q.cls;
    memwb_d.wr  = exmem_q.wr;
    memwb_d.dst = exmem_q.dst;
    memwb_d.alu = exmem_q.alu;
    memwb_d.lmd = Mem[mem_idx(exmem_q.alu)];
    memwb_vld_d = exmem_vld_q;
    mem_we      = exmem_vld_q && (exmem_q.cls == STORE) && !HALTED;
  end

  // ---------------- WB ----------------
  // HLT retiring from WB latches HALTED; the branch pulse follows EX
  always_comb begin
    halted_d       = HALTED || (memwb_vld_q && (memwb_q.cls == HALT));
    taken_branch_d = ex_taken;
  end

  // Control state: PC, status flags and every stage valid bit
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      halt_fetch_q <= 1'b0;
      ifid_vld_q   <= 1'b0;
      idex_vld_q   <= 1'b0;
      exmem_vld_q  <= 1'b0;
      memwb_vld_q  <= 1'b0;
    end else begin
      PC           <= pc_d;
      HALTED       <= halted_d;
      TAKEN_BRANCH <= taken_branch_d;
      halt_fetch_q <= halt_fetch_d;
      ifid_vld_q   <= ifid_vld_d;
      idex_vld_q   <= idex_vld_d;
      exmem_vld_q  <= exmem_vld_d;
      memwb_vld_q  <= memwb_vld_d;
    end
  end

  // Pipeline data payloads; meaningless while their valid bit is clear
  always_ff @(posedge clk1) begin
    ifid_q  <= ifid_d;
    idex_q  <= idex_d;
    exmem_q <= exmem_d;
    memwb_q <= memwb_d;
  end

  // Store port of the unified memory
  always_ff @(posedge clk1) begin
    if (mem_we) begin
      Mem[mem_idx(exmem_q.alu)] <= exmem_q.sdata;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Self-checking bench for pipe_mips32: small programs are preloaded
// through the hierarchy, expected architectural results are queued when
// a program is set up and compared once the pipeline halts.
module tb_pipe_mips32;
  import pipe_mips32_pkg::*;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk1 = ~clk1;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk1  (clk1),
    .rst_n (rst_n)
  );

  typedef struct packed {
    logic        is_mem;
    logic [15:0] idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] r2_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          tb_cnt   = 0;
  bit          track_r2 = 1'b0;
  logic [31:0] r2_last  = 32'd0;
  int          cyc;

  logic [31:0] fact [0:10] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000,
                               32'h21430000, 32'h0e94a000, 32'h14431000,
                               32'h2c630001, 32'h0e94a000, 32'h3460fffc,
                               32'h2542fffe, 32'hfc000000};

  localparam logic [31:0] HLT_W = {OP_HLT, 26'd0};
  localparam logic [31:0] NOP_W = {6'd20, 26'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic push_reg(input int idx, input logic [31:0] val);
    exp_t e;
    e.is_mem = 1'b0;
    e.idx    = 16'(idx);
    e.val    = val;
    sb_q.push_back(e);
  endtask

  task automatic push_mem(input int idx, input logic [31:0] val);
    exp_t e;
    e.is_mem = 1'b1;
    e.idx    = 16'(idx);
    e.val    = val;
    sb_q.push_back(e);
  endtask

  // Hold reset, confirm the cleared state, wipe memory and preload Reg[k]=k
  task automatic begin_test();
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", 32'(dut.HALTED), 32'd0);
    check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.u_rf.Reg[k] = 32'(k);
    sb_q.delete();
    r2_q.delete();
    tb_cnt   = 0;
    track_r2 = 1'b0;
  endtask

  task automatic go();
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max, output int cycles);
    cycles = 0;
    while (!dut.HALTED && cycles < max) begin
      @(negedge clk1);
      cycles++;
    end
    check("halt_seen", 32'(dut.HALTED), 32'd1);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_mem) check($sformatf("mem[%0d]", e.idx), dut.Mem[e.idx], e.val);
      else          check($sformatf("r%0d", e.idx), dut.u_rf.Reg[e.idx[4:0]], e.val);
    end
  endtask

  // Branch pulse counter and Reg[2] value-sequence scoreboard
  always @(negedge clk1) begin
    if (rst_n) begin
      if (dut.TAKEN_BRANCH) tb_cnt++;
      if (track_r2 && (dut.u_rf.Reg[2] !== r2_last)) begin
        r2_last = dut.u_rf.Reg[2];
        if (r2_q.size() == 0) check("r2_extra_change", 32'(r2_q.size()), 32'd1);
        else                  check("r2_seq", r2_last, r2_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADDI then HLT: result, halt timing and frozen PC
    begin_test();
    dut.Mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    dut.Mem[1] = HLT_W;
    push_reg(1, 32'd5);
    go();
    run_to_halt(50, cyc);
    check("t1_cycles", 32'(cyc), 32'd6);
    drain();
    check("t1_pc", dut.PC, 32'd2);
    repeat (5) @(negedge clk1);
    check("t1_pc_frozen", dut.PC, 32'd2);
    check("t1_r1_kept", dut.u_rf.Reg[1], 32'd5);

    // Forwarding from EX/MEM and MEM/WB, R0 writes ignored, write-through
    begin_test();
    dut.Mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd10);
    dut.Mem[1] = enc_r(OP_ADD, 5'd1, 5'd1, 5'd2);
    dut.Mem[2] = enc_r(OP_ADD, 5'd1, 5'd2, 5'd8);
    dut.Mem[3] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9);
    dut.Mem[4] = enc_r(OP_ADD, 5'd0, 5'd0, 5'd3);
    dut.Mem[5] = enc_i(OP_ADDI, 5'd0, 5'd16, 16'd3);
    dut.Mem[6] = NOP_W;
    dut.Mem[7] = NOP_W;
    dut.Mem[8] = enc_r(OP_ADD, 5'd16, 5'd16, 5'd17);
    dut.Mem[9] = HLT_W;
    push_reg(2, 32'd20);
    push_reg(8, 32'd30);
    push_reg(3, 32'd0);
    push_reg(17, 32'd6);
    go();
    run_to_halt(60, cyc);
    drain();

    // ALU operations, signed compares and wrap-around
    begin_test();
    dut.Mem[0] = enc_i(OP_SLTI, 5'd0, 5'd4, 16'hFFFF);
    dut.Mem[1] = enc_r(OP_SUB, 5'd0, 5'd1, 5'd6);
    dut.Mem[2] = enc_r(OP_SLT, 5'd6, 5'd0, 5'd9);
    dut.Mem[3] = enc_r(OP_MUL, 5'd6, 5'd6, 5'd11);
    dut.Mem[4] = enc_r(OP_AND, 5'd7, 5'd3, 5'd12);
    dut.Mem[5] = enc_r(OP_OR, 5'd8, 5'd5, 5'd13);
    dut.Mem[6] = enc_i(OP_SUBI, 5'd2, 5'd14, 16'd5);
    dut.Mem[7] = HLT_W;
    push_reg(4, 32'd0);
    push_reg(6, 32'hFFFF_FFFF);
    push_reg(9, 32'd1);
    push_reg(11, 32'd1);
    push_reg(12, 32'd3);
    push_reg(13, 32'd13);
    push_reg(14, 32'hFFFF_FFFD);
    go();
    run_to_halt(60, cyc);
    drain();

    // Load-use timing, stores with forwarded data, address wrap
    begin_test();
    dut.Mem[50]   = 32'd77;
    dut.Mem[1023] = 32'h1234_5678;
    dut.Mem[0] = enc_i(OP_LW, 5'd0, 5'd1, 16'd50);
    dut.Mem[1] = enc_r(OP_ADD, 5'd1, 5'd0, 5'd2);
    dut.Mem[2] = enc_r(OP_ADD, 5'd1, 5'd0, 5'd3);
    dut.Mem[3] = enc_i(OP_SW, 5'd0, 5'd3, 16'd60);
    dut.Mem[4] = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd4);
    dut.Mem[5] = enc_i(OP_SW, 5'd5, 5'd5, 16'd58);
    dut.Mem[6] = enc_i(OP_LW, 5'd0, 5'd9, 16'hFFFF);
    dut.Mem[7] = HLT_W;
    push_reg(1, 32'd77);
    push_reg(2, 32'd1);
    push_reg(3, 32'd77);
    push_mem(60, 32'd77);
    push_mem(62, 32'd4);
    push_reg(9, 32'h1234_5678);
    go();
    run_to_halt(60, cyc);
    drain();

    // Factorial of 4
    begin_test();
    for (int i = 0; i < 11; i++) dut.Mem[i] = fact[i];
    dut.Mem[200] = 32'd4;
    r2_q.push_back(32'd1);
    r2_q.push_back(32'd4);
    r2_q.push_back(32'd12);
    r2_q.push_back(32'd24);
    r2_last  = 32'd2;
    track_r2 = 1'b1;
    push_mem(198, 32'd24);
    push_mem(200, 32'd4);
    push_reg(2, 32'd24);
    push_reg(3, 32'd0);
    go();
    run_to_halt(300, cyc);
    drain();
    check("fact_r2_pending", 32'(r2_q.size()), 32'd0);
    check("fact_taken_cycles", 32'(tb_cnt), 32'd3);
    track_r2 = 1'b0;

    // Taken BEQZ squashes the two younger instructions
    begin_test();
    dut.Mem[0] = enc_i(OP_BEQZ, 5'd0, 5'd0, 16'd2);
    dut.Mem[1] = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd7);
    dut.Mem[2] = HLT_W;
    dut.Mem[3] = enc_i(OP_ADDI, 5'd0, 5'd7, 16'd9);
    dut.Mem[4] = HLT_W;
    push_reg(5, 32'd5);
    push_reg(7, 32'd9);
    go();
    run_to_halt(60, cyc);
    check("br_halt_cycles", 32'(cyc), 32'd9);
    check("br_taken_cycles", 32'(tb_cnt), 32'd1);
    drain();

    // Reset in the middle of a long factorial loop, then rerun to completion
    begin_test();
    for (int i = 0; i < 11; i++) dut.Mem[i] = fact[i];
    dut.Mem[200] = 32'd12;
    dut.Mem[198] = 32'hDEAD_BEEF;
    go();
    repeat (30) @(negedge clk1);
    check("mid_running", 32'(dut.HALTED), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.PC, 32'd0);
    check("mid_rst_halted", 32'(dut.HALTED), 32'd0);
    check("mid_rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    repeat (5) @(negedge clk1);
    check("mid_r10_kept", dut.u_rf.Reg[10], 32'd200);
    check("mid_r20_kept", dut.u_rf.Reg[20], 32'd20);
    check("mid_mem200_kept", dut.Mem[200], 32'd12);
    check("mid_mem198_untouched", dut.Mem[198], 32'hDEAD_BEEF);
    check("mid_mem0_kept", dut.Mem[0], 32'h280a00c8);
    tb_cnt = 0;
    push_mem(198, 32'd479001600);
    push_reg(2, 32'd479001600);
    push_reg(3, 32'd0);
    go();
    run_to_halt(400, cyc);
    drain();
    check("rerun_taken_cycles", 32'(tb_cnt), 32'd11);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
